sport0_rx_ctl: RTL and testbench

//  Receive control for SPORT0: the receive half of the serial port driven by the SPORT0 transmit control.

---
 rtl/sport0_rx_ctl.sv | 191 +++++++++++++++++++
 tb/tb_sport0_rx_ctl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sport0_rx_ctl.sv
// ---------------------------------------------------------------------------
// sport0_rx_ctl
//   Receive control for SPORT0. Samples RFS/DR on each SCLK sampling strobe,
//   assembles words of SLEN+1 bits (MSB first), supports multichannel frames
//   of MWORD+1 back-to-back words, moves each finished word into the RX
//   holding register and then notifies the core (IRS) or the autobuffer DMA
//   (RSreq).
//
// Ports
//   DSPCLK    in   system clock, all state changes on posedge
//   RST       in   synchronous active-high reset
//   SP_EN     in   port enable; low clears FSM, counters and shifter
//   SCLK_en   in   one-DSPCLK strobe at each SCLK sampling edge
//   RFS       in   receive frame sync (sampled only while idle)
//   DR        in   serial receive data
//   SLEN      in   word length - 1 (2..15)
//   MWORD     in   words per frame - 1
//   RXSE      in   1 = sign-extend received word, 0 = zero-fill
//   RBUF      in   1 = autobuffer (DMA) mode
//   Rwrap     in   autobuffer wrap indication, routed to IRS in RBUF mode
//   RX_re     in   core read strobe of RX
//   RSack     in   DMA acknowledge
//   ROVF_clr  in   clears the sticky overflow flag
//   RX        out  received word holding register
//   RX_full   out  RX holds an unread word
//   RSreq     out  DMA request
//   IRS       out  receive interrupt
//   ROVF      out  sticky overflow flag
//   SLOT_NUM  out  current multichannel slot (counts MWORD..0)
// ---------------------------------------------------------------------------
module sport0_rx_ctl #(
  parameter int DW     = 16,
  parameter int WCNT_W = 8
) (
  input  logic              DSPCLK,
  input  logic              RST,
  input  logic              SP_EN,
  input  logic              SCLK_en,
  input  logic              RFS,
  input  logic              DR,
  input  logic [3:0]        SLEN,
  input  logic [WCNT_W-1:0] MWORD,
  input  logic              RXSE,
  input  logic              RBUF,
  input  logic              Rwrap,
  input  logic              RX_re,
  input  logic              RSack,
  input  logic              ROVF_clr,
  output logic [DW-1:0]     RX,
  output logic              RX_full,
  output logic              RSreq,
  output logic              IRS,
  output logic              ROVF,
  output logic [3:0]        SLOT_NUM
);

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    SHIFT = 2'b10
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        bcnt, bcnt_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic [DW-1:0]     shifter, shifter_nxt;
  logic [DW-1:0]     shift_in;
  logic [DW-1:0]     word_ext;
  logic              word_done;
  logic              done_q;
  logic              rx_clr;

  assign shift_in = {shifter[DW-2:0], DR};
  assign rx_clr   = RX_re | RSack;

  // The frame-sync strobe only arms the counters; the data bits follow on
  // the next strobes. Bcnt counts down to 0, and the strobe seen at 0 is the
  // last bit of the word. Dropping SP_EN overrides everything and discards a
  // partly received word.
  always_comb begin
    state_nxt   = state;
    bcnt_nxt    = bcnt;
    wcnt_nxt    = wcnt;
    shifter_nxt = shifter;
    word_done   = 1'b0;
    case (state)
      IDLE: begin
        if (SCLK_en && RFS) begin
          state_nxt   = SHIFT;
          bcnt_nxt    = SLEN;
          wcnt_nxt    = MWORD;
          shifter_nxt = '0;
        end
      end
      SHIFT: begin
        if (SCLK_en) begin
          if (bcnt == 4'd0) begin
            word_done   = 1'b1;
            shifter_nxt = '0;
            if (wcnt == '0) begin
              state_nxt = IDLE;
            end else begin
              bcnt_nxt = SLEN;
              wcnt_nxt = wcnt - {{(WCNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            shifter_nxt = shift_in;
            bcnt_nxt    = bcnt - 4'd1;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        bcnt_nxt    = '0;
        wcnt_nxt    = '0;
        shifter_nxt = '0;
      end
    endcase
    if (!SP_EN) begin
      state_nxt   = IDLE;
      bcnt_nxt    = '0;
      wcnt_nxt    = '0;
      shifter_nxt = '0;
      word_done   = 1'b0;
    end
  end

  // Bits above the word length are filled with the word MSB or with zero.
  always_comb begin
    word_ext = '0;
    for (int i = 0; i < DW; i++) begin
      if (i <= int'(SLEN)) begin
        word_ext[i] = shift_in[i];
      end else begin
        word_ext[i] = RXSE & shift_in[SLEN];
      end
    end
  end

  always_ff @(posedge DSPCLK) begin
    if (RST) begin
      state   <= IDLE;
      bcnt    <= '0;
      wcnt    <= '0;
      shifter <= '0;
    end else begin
      state   <= state_nxt;
      bcnt    <= bcnt_nxt;
      wcnt    <= wcnt_nxt;
      shifter <= shifter_nxt;
    end
  end

  // Holding register and handshake flags. A load beats a same-cycle clear of
  // RX_full, and a same-cycle clear also cancels the overflow condition.
  // While the port is disabled the user-visible flags simply hold.
  always_ff @(posedge DSPCLK) begin
    if (RST) begin
      RX      <= '0;
      RX_full <= 1'b0;
      ROVF    <= 1'b0;
      RSreq   <= 1'b0;
      done_q  <= 1'b0;
    end else if (SP_EN) begin
      done_q <= word_done;
      if (word_done) begin
        RX <= word_ext;
      end
      if (word_done) begin
        RX_full <= 1'b1;
      end else if (rx_clr) begin
        RX_full <= 1'b0;
      end
      if (word_done && RX_full && !rx_clr) begin
        ROVF <= 1'b1;
      end else if (ROVF_clr) begin
        ROVF <= 1'b0;
      end
      if (RSack) begin
        RSreq <= 1'b0;
      end else if (done_q && RBUF) begin
        RSreq <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign IRS      = RBUF ? Rwrap : done_q;
  assign SLOT_NUM = wcnt[3:0];

endmodule

// File: tb/tb_sport0_rx_ctl.sv
// ---------------------------------------------------------------------------
// tb_sport0_rx_ctl
//   Directed bench for sport0_rx_ctl. Stimulus pushes each expected RX word
//   into a queue; an independent monitor pops and compares whenever the DUT
//   announces a load (IRS pulse, or RSreq rising in autobuffer mode).
// ---------------------------------------------------------------------------
module tb_sport0_rx_ctl;

  logic        DSPCLK;
  logic        RST;
  logic        SP_EN;
  logic        SCLK_en;
  logic        RFS;
  logic        DR;
  logic [3:0]  SLEN;
  logic [7:0]  MWORD;
  logic        RXSE;
  logic        RBUF;
  logic        Rwrap;
  logic        RX_re;
  logic        RSack;
  logic        ROVF_clr;
  logic [15:0] RX;
  logic        RX_full;
  logic        RSreq;
  logic        IRS;
  logic        ROVF;
  logic [3:0]  SLOT_NUM;

  int          vectorCount = 0;
  int          failCount   = 0;
  int          irsCount    = 0;
  int          irsSnap;
  logic        rsreqPrev   = 1'b0;
  logic [15:0] expQ[$];

  sport0_rx_ctl #(.DW(16), .WCNT_W(8)) dut (
    .DSPCLK   (DSPCLK),
    .RST      (RST),
    .SP_EN    (SP_EN),
    .SCLK_en  (SCLK_en),
    .RFS      (RFS),
    .DR       (DR),
    .SLEN     (SLEN),
    .MWORD    (MWORD),
    .RXSE     (RXSE),
    .RBUF     (RBUF),
    .Rwrap    (Rwrap),
    .RX_re    (RX_re),
    .RSack    (RSack),
    .ROVF_clr (ROVF_clr),
    .RX       (RX),
    .RX_full  (RX_full),
    .RSreq    (RSreq),
    .IRS      (IRS),
    .ROVF     (ROVF),
    .SLOT_NUM (SLOT_NUM)
  );

  // 10 ns system clock
  initial begin
    DSPCLK = 1'b0;
    forever #5 DSPCLK = ~DSPCLK;
  end

  // Monitor: compares RX against the scoreboard whenever the DUT signals a
  // finished word, sampling on the falling edge.
  always @(negedge DSPCLK) begin
    logic [15:0] expWord;
    if (!RST) begin
      if ((!RBUF && IRS) || (RBUF && RSreq && !rsreqPrev)) begin
        vectorCount++;
        if (expQ.size() == 0) begin
          failCount++;
          $display("[TB] FAIL unexpected_load: RX=%h, no word expected", RX);
        end else begin
          expWord = expQ.pop_front();
          if (RX !== expWord) begin
            failCount++;
            $display("[TB] FAIL rx_word: got %h, expected %h", RX, expWord);
          end
        end
      end
      if (!RBUF && IRS) irsCount++;
    end
    rsreqPrev = RSreq;
  end

  task automatic tick();
    @(posedge DSPCLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One SCLK strobe followed by three quiet DSPCLK cycles. reSame asserts
  // RX_re together with the strobe; ackNext asserts RSack in the cycle
  // right after it.
  task automatic applyStimulus(input logic rfs, input logic dr, input logic reSame, input logic ackNext);
    SCLK_en = 1'b1;
    RFS     = rfs;
    DR      = dr;
    RX_re   = reSame;
    tick();
    SCLK_en = 1'b0;
    RFS     = 1'b0;
    DR      = 1'b0;
    RX_re   = 1'b0;
    RSack   = ackNext;
    tick();
    RSack   = 1'b0;
    tick();
    tick();
  endtask

  task automatic sendWord(input logic [15:0] value, input int nbits, input bit withFs,
                          input bit reLast, input bit ackLast, input int fsAt);
    if (withFs) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = nbits - 1; i >= 0; i--) begin
      applyStimulus(i == fsAt, value[i], reLast && (i == 0), ackLast && (i == 0));
    end
  endtask

  task automatic readRx();
    RX_re = 1'b1;
    tick();
    RX_re = 1'b0;
  endtask

  task automatic ackDma();
    RSack = 1'b1;
    tick();
    RSack = 1'b0;
  endtask

  initial begin
    RST = 1'b1; SP_EN = 1'b0; SCLK_en = 1'b0; RFS = 1'b0; DR = 1'b0;
    SLEN = 4'd7; MWORD = 8'd0; RXSE = 1'b0; RBUF = 1'b0; Rwrap = 1'b0;
    RX_re = 1'b0; RSack = 1'b0; ROVF_clr = 1'b0;
    tick(); tick(); tick();

    // reset state
    checkOutput("reset_RX", RX, 16'h0000);
    checkOutput("reset_RX_full", RX_full, 0);
    checkOutput("reset_RSreq", RSreq, 0);
    checkOutput("reset_IRS", IRS, 0);
    checkOutput("reset_ROVF", ROVF, 0);
    checkOutput("reset_SLOT_NUM", SLOT_NUM, 0);
    RST = 1'b0; SP_EN = 1'b1;
    tick();

    // 8-bit word, zero fill
    expQ.push_back(16'h00A5);
    sendWord(16'h00A5, 8, 1, 0, 0, -1);
    checkOutput("t1_RX_full", RX_full, 1);
    checkOutput("t1_irs_pulses", irsCount, 1);
    checkOutput("t1_ROVF", ROVF, 0);
    readRx();
    checkOutput("t1_RX_full_cleared", RX_full, 0);

    // sign extension; an RFS during data bits is ignored
    RXSE = 1'b1;
    expQ.push_back(16'hFFA5);
    sendWord(16'h00A5, 8, 1, 0, 0, -1);
    readRx();
    expQ.push_back(16'h005A);
    sendWord(16'h005A, 8, 1, 0, 0, 3);
    readRx();
    checkOutput("t2_irs_pulses", irsCount, 3);

    // 3-word multichannel frame of 16-bit words
    RXSE = 1'b0; SLEN = 4'd15; MWORD = 8'd2;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_slot_first", SLOT_NUM, 2);
    expQ.push_back(16'h1234);
    sendWord(16'h1234, 16, 0, 0, 0, -1);
    readRx();
    checkOutput("t3_slot_second", SLOT_NUM, 1);
    expQ.push_back(16'h5678);
    sendWord(16'h5678, 16, 0, 0, 0, -1);
    readRx();
    checkOutput("t3_slot_third", SLOT_NUM, 0);
    expQ.push_back(16'h9ABC);
    sendWord(16'h9ABC, 16, 0, 0, 0, -1);
    readRx();
    checkOutput("t3_ROVF", ROVF, 0);
    checkOutput("t3_RX_full", RX_full, 0);

    // overflow, clear, load racing a read
    SLEN = 4'd7; MWORD = 8'd0;
    expQ.push_back(16'h0011);
    sendWord(16'h0011, 8, 1, 0, 0, -1);
    expQ.push_back(16'h0022);
    sendWord(16'h0022, 8, 1, 0, 0, -1);
    checkOutput("t4_ROVF_set", ROVF, 1);
    checkOutput("t4_RX_overwritten", RX, 16'h0022);
    ROVF_clr = 1'b1;
    tick();
    ROVF_clr = 1'b0;
    checkOutput("t4_ROVF_cleared", ROVF, 0);
    expQ.push_back(16'h0033);
    sendWord(16'h0033, 8, 1, 1, 0, -1);
    checkOutput("t4_load_beats_read", RX_full, 1);
    checkOutput("t4_no_ROVF", ROVF, 0);
    readRx();

    // autobuffer mode
    RBUF = 1'b1;
    expQ.push_back(16'h0044);
    sendWord(16'h0044, 8, 1, 0, 0, -1);
    checkOutput("t5_RSreq_w1", RSreq, 1);
    ackDma();
    checkOutput("t5_RSreq_ack_w1", RSreq, 0);
    checkOutput("t5_RX_full_ack_w1", RX_full, 0);
    expQ.push_back(16'h0055);
    sendWord(16'h0055, 8, 1, 0, 0, -1);
    checkOutput("t5_RSreq_w2", RSreq, 1);
    ackDma();
    checkOutput("t5_RSreq_ack_w2", RSreq, 0);
    sendWord(16'h0066, 8, 1, 0, 1, -1);
    checkOutput("t5_ack_beats_set", RSreq, 0);
    checkOutput("t5_RX_w3", RX, 16'h0066);
    Rwrap = 1'b1;
    #1;
    checkOutput("t5_IRS_wrap_hi", IRS, 1);
    Rwrap = 1'b0;
    #1;
    checkOutput("t5_IRS_wrap_lo", IRS, 0);
    RBUF = 1'b0;
    tick();

    // disable mid-word, then a clean word, then reset mid-word
    irsSnap = irsCount;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 7; i >= 3; i--) applyStimulus(1'b0, i[0], 1'b0, 1'b0);
    SP_EN = 1'b0;
    tick(); tick();
    SP_EN = 1'b1;
    tick();
    checkOutput("t6_RX_held", RX, 16'h0066);
    checkOutput("t6_no_load", irsCount, irsSnap);
    checkOutput("t6_RX_full_held", RX_full, 0);
    expQ.push_back(16'h00C3);
    sendWord(16'h00C3, 8, 1, 0, 0, -1);
    MWORD = 8'd3;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_slot_before_rst", SLOT_NUM, 3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkOutput("t6_rst_RX", RX, 16'h0000);
    checkOutput("t6_rst_RX_full", RX_full, 0);
    checkOutput("t6_rst_RSreq", RSreq, 0);
    checkOutput("t6_rst_IRS", IRS, 0);
    checkOutput("t6_rst_ROVF", ROVF, 0);
    checkOutput("t6_rst_SLOT_NUM", SLOT_NUM, 0);
    tick(); tick();

    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
